// File: rtl/commit_trace_tx.sv
// Commit-trace producer: buffers retired-instruction records and streams them as 32-bit words.
// Optional feature: define TRACE_CSUM_EN to append an XOR checksum word to each record.
module commit_trace_tx #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit_valid,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_instr,
  input  logic [31:0]      commit_rd,
  input  logic [31:0]      commit_rs,
  input  logic [31:0]      commit_rt,
  input  logic [31:0]      v0_val,
  output logic             tx_valid,
  output logic [31:0]      tx_data,
  output logic             tx_last,
  input  logic             tx_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             halt_seen,
  output logic             done
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned REC_W  = 160;
`ifdef TRACE_CSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif
  localparam logic [0:0]  ST_IDLE    = 1'b0;
  localparam logic [0:0]  ST_SEND    = 1'b1;
  localparam logic [31:0] EXIT_INSTR = 32'h0000000c;
  localparam logic [31:0] EXIT_V0    = 32'h0000000a;

  logic [REC_W-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   rd_ptr_inc;
  logic              empty;
  logic              full;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              drop;
  logic              is_exit;
  logic              more;
  logic [REC_W-1:0]  commit_rec;
  logic [REC_W-1:0]  head_rec;
  logic [REC_W-1:0]  next_rec;

  logic [0:0]        state;
  logic [0:0]        state_n;
  logic [2:0]        idx;
  logic [2:0]        idx_n;
  logic [2:0]        idx_inc;
  logic              tx_valid_n;
  logic              tx_last_n;
  logic [31:0]       tx_data_n;

  // Select word i of a record; word 0 is the PC in the low bits.
  function automatic logic [31:0] rec_word(input logic [REC_W-1:0] r, input logic [2:0] i);
    logic [31:0] w;
    w = '0;
    case (i)
      3'd0:    w = r[31:0];
      3'd1:    w = r[63:32];
      3'd2:    w = r[95:64];
      3'd3:    w = r[127:96];
      3'd4:    w = r[159:128];
`ifdef TRACE_CSUM_EN
      3'd5:    w = r[31:0] ^ r[63:32] ^ r[95:64] ^ r[127:96] ^ r[159:128];
`endif
      default: w = '0;
    endcase
    return w;
  endfunction

  assign commit_rec = {commit_rt, commit_rs, commit_rd, commit_instr, commit_pc};
  assign is_exit    = (commit_instr == EXIT_INSTR) && (v0_val == EXIT_V0);

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign rd_ptr_inc = rd_ptr + (ADDR_W+1)'(1);

  assign pop        = (state == ST_SEND) && tx_valid && tx_ready && (idx == LAST_IDX);
  assign push_req   = commit_valid && !halt_seen;
  assign push_ok    = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;

  // A record entering the FIFO in the same cycle as the head pops is forwarded directly.
  assign head_rec   = mem[rd_ptr[ADDR_W-1:0]];
  assign more       = (rd_ptr_inc != wr_ptr) || push_ok;
  assign next_rec   = (rd_ptr_inc == wr_ptr) ? commit_rec : mem[rd_ptr_inc[ADDR_W-1:0]];
  assign idx_inc    = idx + 3'd1;

  assign done       = halt_seen && empty && (state == ST_IDLE);

  // Serializer next-state and next-output logic
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    tx_valid_n = tx_valid;
    tx_data_n  = tx_data;
    tx_last_n  = tx_last;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_n    = ST_SEND;
          idx_n      = 3'd0;
          tx_valid_n = 1'b1;
          tx_data_n  = rec_word(head_rec, 3'd0);
          tx_last_n  = 1'b0;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (idx == LAST_IDX) begin
            idx_n     = 3'd0;
            tx_last_n = 1'b0;
            if (more) begin
              tx_data_n = rec_word(next_rec, 3'd0);
            end else begin
              state_n    = ST_IDLE;
              tx_valid_n = 1'b0;
            end
          end else begin
            idx_n     = idx_inc;
            tx_data_n = rec_word(head_rec, idx_inc);
            tx_last_n = (idx_inc == LAST_IDX);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      tx_last   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      halt_seen <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      tx_valid <= tx_valid_n;
      tx_data  <= tx_data_n;
      tx_last  <= tx_last_n;
      if (push_ok) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (pop)     rd_ptr <= rd_ptr_inc;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (push_req && is_exit) halt_seen <= 1'b1;
    end
  end

  // Record storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr[ADDR_W-1:0]] <= commit_rec;
  end

endmodule

// File: tb/tb_commit_trace_tx.sv
// Scoreboard bench for commit_trace_tx: directed scenarios plus randomized traffic.
module tb_commit_trace_tx;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;
`ifdef TRACE_CSUM_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  logic clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  logic             reset;
  logic             commit_valid;
  logic [31:0]      commit_pc, commit_instr, commit_rd, commit_rs, commit_rt, v0_val;
  logic             tx_valid, tx_last, tx_ready;
  logic [31:0]      tx_data;
  logic             overflow, halt_seen, done;
  logic [CNT_W-1:0] drop_cnt;

  commit_trace_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk_tb), .reset(reset), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_instr(commit_instr), .commit_rd(commit_rd),
    .commit_rs(commit_rs), .commit_rt(commit_rt), .v0_val(v0_val),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .overflow(overflow), .drop_cnt(drop_cnt), .halt_seen(halt_seen), .done(done)
  );

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } word_t;

  word_t            exp_q[$];
  word_t            mon_e;
  int               checks = 0;
  int               failures = 0;
  int               m_occ = 0;
  int               m_hs = 0;
  logic             m_ovf = 1'b0;
  logic             m_halt = 1'b0;
  logic [CNT_W-1:0] m_drop = '0;
  bit               mon_en = 1'b0;
  bit               pop_now;
  logic             stall_prev = 1'b0;
  logic [31:0]      stall_data = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_rec(input logic [31:0] a, b, c, d, e);
    logic [31:0] ws [6];
    ws = '{a, b, c, d, e, a ^ b ^ c ^ d ^ e};
    for (int i = 0; i < NW; i++) exp_q.push_back(word_t'{last: (i == NW - 1), data: ws[i]});
  endtask

  // Reference model: applies the upcoming edge's effect, evaluated mid-cycle.
  always @(negedge clk_tb) begin
    #1;
    if (reset) begin
      exp_q.delete();
      m_occ = 0; m_hs = 0; m_ovf = 1'b0; m_halt = 1'b0; m_drop = '0;
    end else begin
      pop_now = 1'b0;
      if (tx_valid && tx_ready) begin
        if (m_hs == NW - 1) begin
          pop_now = 1'b1;
          m_hs = 0;
        end else begin
          m_hs++;
        end
      end
      if (commit_valid && !m_halt) begin
        if (m_occ < DEPTH || pop_now) begin
          push_rec(commit_pc, commit_instr, commit_rd, commit_rs, commit_rt);
          m_occ++;
        end else begin
          m_ovf = 1'b1;
          if (m_drop != {CNT_W{1'b1}}) m_drop = m_drop + 1'b1;
        end
        if (commit_instr == 32'hc && v0_val == 32'ha) m_halt = 1'b1;
      end
      if (pop_now) m_occ--;
    end
  end

  // Monitor: status flags every cycle, stream words on each handshake.
  always @(negedge clk_tb) begin
    if (mon_en) begin
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      check("halt_seen", 64'(halt_seen), 64'(m_halt));
      check("done", 64'(done), 64'(m_halt && m_occ == 0));
      if (stall_prev) begin
        check("stall_valid", 64'(tx_valid), 64'd1);
        check("stall_data", 64'(tx_data), 64'(stall_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word got=%0h exp=none", tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("word", 64'({tx_last, tx_data}), 64'({mon_e.last, mon_e.data}));
        end
      end
      stall_prev = tx_valid && !tx_ready && !reset;
      stall_data = tx_data;
    end
  end

  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic set_commit(input logic [31:0] pc, instr, rd, rs, rt, v0);
    commit_valid = 1'b1;
    commit_pc = pc; commit_instr = instr; commit_rd = rd;
    commit_rs = rs; commit_rt = rt; v0_val = v0;
  endtask

  task automatic rand_commit(input bit allow_exit);
    logic [31:0] instr;
    instr = $urandom;
    if (!allow_exit) instr = instr | 32'h8000_0000;
    else if ($urandom_range(0, 31) == 0) instr = 32'hc;
    set_commit($urandom, instr, $urandom, $urandom, $urandom,
               ($urandom_range(0, 1) == 1) ? 32'ha : $urandom);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    commit_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    commit_valid = 1'b0;
    tx_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || tx_valid) begin
      failures++;
      $display("FAIL drain_%s got=%0d words pending exp=0", name, exp_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; commit_valid = 1'b0; tx_ready = 1'b0;
    commit_pc = '0; commit_instr = '0; commit_rd = '0; commit_rs = '0; commit_rt = '0; v0_val = '0;
    tick();
    mon_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_tx_last", 64'(tx_last), 64'd0);

    // Single record: latency and consecutive words
    tx_ready = 1'b1;
    set_commit(32'h00400000, 32'h20020005, 32'd5, 32'd0, 32'd5, 32'd0);
    tick();
    commit_valid = 1'b0;
    check("lat_edge_n", 64'(tx_valid), 64'd0);
    tick();
    check("lat_valid", 64'(tx_valid), 64'd1);
    check("lat_word0", 64'(tx_data), 64'h00400000);
    repeat (4) tick();
    check("t1_word4", 64'(tx_data), 64'd5);
    check("t1_last", 64'(tx_last), 64'(NW == 5));
    drain("t1");

    // Back-pressure held on word 2
    set_commit(32'h100, 32'h200, 32'hdeadbeef, 32'd1, 32'd2, 32'd0);
    tick();
    commit_valid = 1'b0;
    repeat (3) tick();
    check("t2_word2", 64'(tx_data), 64'hdeadbeef);
    tx_ready = 1'b0;
    repeat (3) begin
      tick();
      check("t2_hold_valid", 64'(tx_valid), 64'd1);
      check("t2_hold_data", 64'(tx_data), 64'hdeadbeef);
    end
    drain("t2");

    // Overflow: 10 commits into a stalled 8-deep FIFO
    tx_ready = 1'b0;
    repeat (10) begin
      rand_commit(1'b0);
      tick();
    end
    commit_valid = 1'b0;
    tick();
    check("t3_drop_cnt", 64'(drop_cnt), 64'd2);
    check("t3_overflow", 64'(overflow), 64'd1);
    drain("t3");

    // Reset during word 3 clears sticky state and aborts the record
    tx_ready = 1'b1;
    set_commit(32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 32'd0);
    tick();
    commit_valid = 1'b0;
    repeat (4) tick();
    check("t5_word3", 64'(tx_data), 64'h43);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_valid", 64'(tx_valid), 64'd0);
    check("t5_overflow", 64'(overflow), 64'd0);
    check("t5_drop", 64'(drop_cnt), 64'd0);
    set_commit(32'h50, 32'h51, 32'h52, 32'h53, 32'h54, 32'd0);
    tick();
    drain("t5");

    // Exit record then ignored commits
    set_commit(32'h00400100, 32'h0000000c, 32'd0, 32'd0, 32'd0, 32'h0000000a);
    tick();
    repeat (2) begin
      rand_commit(1'b0);
      tick();
    end
    commit_valid = 1'b0;
    check("t4_halt", 64'(halt_seen), 64'd1);
    drain("t4");
    check("t4_done", 64'(done), 64'd1);
    check("t4_drop", 64'(drop_cnt), 64'd0);
    pulse_reset();
    check("t4_done_clr", 64'(done), 64'd0);

    // Checksum-friendly record
    set_commit(32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd0);
    tick();
    drain("t6");

    // Randomized traffic with occasional resets
    repeat (800) begin
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 2) != 0) rand_commit(1'b1);
      else commit_valid = 1'b0;
      tx_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 1'b0;
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
